morse_symbol_framer: RTL and testbench
======================================

Name: morse_symbol_framer

Overview:
- Upstream front end of the Morse decode path. Sits between the raw `morse` key input and the processor's morse receiver.
- Synchronizes and debounces the key, measures mark and space durations, and classifies each element as dot or dash.
- Packs the elements of one letter into a code record and emits it, plus word-end records, over a valid/ready handshake.

Parameters:
- UNIT_CYCLES, 60: clock cycles per Morse time unit.
- DEBOUNCE_CYCLES, 4: cycles the synchronized input must hold stable before the debounced level changes.
- CNT_W, 16: width of the mark/space duration counters; counters saturate at all-ones.
- MAX_ELEM, 5: maximum elements per letter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- morse  in  1  raw key level, asynchronous to clock; 1 = key down (mark).
- code_ready  in  1  downstream accepts the record this cycle.
- code_valid  out  1  record valid; held until accepted.
- code_bits  out  5  element pattern; bit i = element i, 1 = dash, 0 = dot; first element is in bit 0; unused bits are 0.
- code_len  out  3  number of elements, 0..5; 0 only for word-end records.
- word_end  out  1  record marks a word gap.
- too_long  out  1  the letter had more than MAX_ELEM elements; extra elements were dropped.
- overrun  out  1  sticky: a record was lost because the output slot was full.

Behaviour:
- Reset: clock and reset are fixed as one clock with asynchronous active-high reset. Reset clears all state immediately. All outputs go to 0; the FSM enters IDLE; the debounced level is 0.
- Reset mid-operation: a partially built letter is discarded and nothing is emitted for it.
- Input conditioning:
  - Two-flop synchronizer on `morse`.
  - Debounced level toggles only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Shorter glitches are ignored entirely.
- FSM states: IDLE, MARK, SPACE.
  - IDLE: waiting for the first mark. Debounced rise -> MARK, mark counter set to 1.
  - MARK: mark counter increments each cycle. On debounced fall:
    - mark count < 2*UNIT_CYCLES -> dot; otherwise dash.
    - If code_len < MAX_ELEM, store the element at bit index code_len and increment code_len. Otherwise set too_long_pending and drop the element.
    - Go to SPACE with the space counter set to 1.
  - SPACE: space counter increments each cycle.
    - Debounced rise -> MARK, with the letter retained.
    - Space count reaching 3*UNIT_CYCLES with code_len > 0: emit a letter record next cycle, then clear the pattern, code_len and too_long_pending.
    - Space count reaching 7*UNIT_CYCLES after a letter was emitted in this space: emit a word-end record {bits=0, len=0, word_end=1}, then go to IDLE.
- Record latency: code_valid rises on the cycle after the threshold count is reached.
- Handshake:
  - The record is transferred when code_valid && code_ready.
  - Output fields stay stable while code_valid is high and code_ready is low.
  - New record while the slot is full and not being accepted: the new record is dropped and overrun is set. overrun clears only on reset.
  - New record in the same cycle the current one is accepted: the new record loads, code_valid stays high, and no overrun occurs.
- Counters saturate at 2^CNT_W-1.
  - A long mark is still classified as a dash.
  - A long space produces exactly one letter record and one word-end record.

Decomposition:
- Package morse_pkg: MAX_ELEM, the unit multipliers (DASH_UNITS=2, LETTER_GAP_UNITS=3, WORD_GAP_UNITS=7), the FSM state encoding, and the record field widths. The downstream receiver shares these.
- One sub-module, morse_debounce: synchronizer plus debounce counter, parameterized by DEBOUNCE_CYCLES. It outputs the debounced level only.
- The FSM, packing logic and output slot stay in the top level.

Test Plan (UNIT_CYCLES=60, DEBOUNCE_CYCLES=4, code_ready=1 unless stated):
- Letter "A": mark 60 cycles, space 60, mark 180, then space 500 -> one record {bits=00010, len=2, word_end=0}, then one word-end record {bits=0, len=0, word_end=1}; no other records.
- Letter "E": a 3-cycle glitch, then mark 60 and space 200 -> single record {bits=00000, len=1}; the glitch produces no element.
- Six dashes each of 180 cycles, separated by 60-cycle spaces, then space 200 -> {bits=11111, len=5, too_long=1}.
- Overrun: code_ready=0; send "E", then "T" (mark 180) -> "E" held stable, "T" dropped, overrun=1 and it persists after code_ready=1.
- Boundary classification: mark of exactly 119 cycles -> dot; mark of exactly 120 cycles -> dash.
- Reset asserted for 1 cycle in the middle of a 180-cycle mark -> all outputs 0 immediately, no record emitted, and the next clean "E" decodes normally.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared Morse constants, FSM encoding and record field widths for the
// framer and the downstream receiver.
package morse_pkg;

    localparam int MAX_ELEM         = 5;
    localparam int DASH_UNITS       = 2;
    localparam int LETTER_GAP_UNITS = 3;
    localparam int WORD_GAP_UNITS   = 7;

    localparam int CODE_BITS_W = 5;
    localparam int CODE_LEN_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2
    } state_t;

endpackage

// File: rtl/morse_debounce.sv
// Two-flop synchronizer and debounce filter for the raw key; the level output
// follows the input 2 + DEBOUNCE_CYCLES cycles later, no backpressure.
module morse_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_raw,
    output logic o_level
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            r_meta;
    logic            r_sync;
    logic            r_level;
    logic [DB_W-1:0] r_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            // Any cycle where the input agrees with the level restarts the run.
            if (r_sync != r_level) begin
                if (r_cnt == DB_LAST) begin
                    r_level <= r_sync;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/morse_symbol_framer.sv
// Morse key front end: times marks/spaces, packs letters, emits letter and word-end
// records one cycle after the gap threshold; a record arriving at a full, unaccepted slot is dropped and flagged.
module morse_symbol_framer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES     = 60,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   morse,
    input  logic                   code_ready,
    output logic                   code_valid,
    output logic [CODE_BITS_W-1:0] code_bits,
    output logic [CODE_LEN_W-1:0]  code_len,
    output logic                   word_end,
    output logic                   too_long,
    output logic                   overrun
);

    localparam logic [CNT_W-1:0] DASH_TH   = CNT_W'(DASH_UNITS * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] LETTER_TH = CNT_W'(LETTER_GAP_UNITS * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] WORD_TH   = CNT_W'(WORD_GAP_UNITS * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CODE_LEN_W-1:0] LEN_MAX = CODE_LEN_W'(MAX_ELEM);

    logic                   w_lvl;
    logic                   r_lvl_d;
    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_W-1:0]       r_mark_cnt;
    logic [CNT_W-1:0]       r_space_cnt;
    logic [CODE_BITS_W-1:0] r_bits;
    logic [CODE_LEN_W-1:0]  r_len;
    logic                   r_too_long_pend;
    logic                   r_letter_sent;

    logic                   r_code_valid;
    logic [CODE_BITS_W-1:0] r_code_bits;
    logic [CODE_LEN_W-1:0]  r_code_len;
    logic                   r_word_end;
    logic                   r_too_long;
    logic                   r_overrun;

    logic w_rise;
    logic w_fall;
    logic w_mark_end;
    logic w_letter_emit;
    logic w_word_gap;
    logic w_word_emit;
    logic w_slot_free;

    morse_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock  (clock),
        .reset  (reset),
        .i_raw  (morse),
        .o_level(w_lvl)
    );

    assign w_rise        = w_lvl & ~r_lvl_d;
    assign w_fall        = ~w_lvl & r_lvl_d;
    assign w_mark_end    = (r_state == MARK) && w_fall;
    assign w_letter_emit = (r_state == SPACE) && (r_space_cnt == LETTER_TH) && (r_len != '0);
    assign w_word_gap    = (r_state == SPACE) && (r_space_cnt == WORD_TH);
    assign w_word_emit   = w_word_gap && r_letter_sent;
    assign w_slot_free   = ~r_code_valid | code_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_rise) w_next_state = MARK;
            MARK:    if (w_fall) w_next_state = SPACE;
            SPACE: begin
                if (w_rise) begin
                    w_next_state = MARK;
                end else if (w_word_gap) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lvl_d         <= 1'b0;
            r_mark_cnt      <= '0;
            r_space_cnt     <= '0;
            r_bits          <= '0;
            r_len           <= '0;
            r_too_long_pend <= 1'b0;
            r_letter_sent   <= 1'b0;
        end else begin
            r_lvl_d <= w_lvl;

            if (w_rise && (r_state != MARK)) begin
                r_mark_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if ((r_state == MARK) && (r_mark_cnt != CNT_MAX)) begin
                r_mark_cnt <= r_mark_cnt + 1'b1;
            end

            if (w_mark_end) begin
                r_space_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if ((r_state == SPACE) && (r_space_cnt != CNT_MAX)) begin
                r_space_cnt <= r_space_cnt + 1'b1;
            end

            if (w_letter_emit) begin
                r_bits          <= '0;
                r_len           <= '0;
                r_too_long_pend <= 1'b0;
            end else if (w_mark_end) begin
                if (r_len < LEN_MAX) begin
                    r_bits[r_len] <= (r_mark_cnt >= DASH_TH);
                    r_len         <= r_len + 1'b1;
                end else begin
                    r_too_long_pend <= 1'b1;
                end
            end

            // Word-end only follows a letter emitted within the same space.
            if (w_next_state == MARK) begin
                r_letter_sent <= 1'b0;
            end else if (w_letter_emit) begin
                r_letter_sent <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_code_valid <= 1'b0;
            r_code_bits  <= '0;
            r_code_len   <= '0;
            r_word_end   <= 1'b0;
            r_too_long   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if ((w_letter_emit || w_word_emit) && w_slot_free) begin
                r_code_valid <= 1'b1;
                r_code_bits  <= w_letter_emit ? r_bits : '0;
                r_code_len   <= w_letter_emit ? r_len : '0;
                r_word_end   <= w_word_emit;
                r_too_long   <= w_letter_emit && r_too_long_pend;
            end else if (code_ready) begin
                r_code_valid <= 1'b0;
            end

            if ((w_letter_emit || w_word_emit) && !w_slot_free) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign code_valid = r_code_valid;
    assign code_bits  = r_code_bits;
    assign code_len   = r_code_len;
    assign word_end   = r_word_end;
    assign too_long   = r_too_long;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_morse_symbol_framer.sv
// Directed bench for morse_symbol_framer: table of letters plus hand-written
// glitch, overrun and mid-mark reset sequences.
module tb_morse_symbol_framer;

    logic       clock;
    logic       reset;
    logic       morse;
    logic       code_ready;
    logic       code_valid;
    logic [4:0] code_bits;
    logic [2:0] code_len;
    logic       word_end;
    logic       too_long;
    logic       overrun;

    typedef struct packed {
        logic       tl;
        logic       we;
        logic [2:0] len;
        logic [4:0] bits;
    } rec_t;

    typedef struct {
        int               n;
        logic [5:0][11:0] marks;
        int               gap;
        int               tail;
        logic [4:0]       bits;
        logic [2:0]       len;
        logic             tl;
        int               nrec;
    } vec_t;

    rec_t recs[$];
    vec_t vecs[$];
    int   n_checks;
    int   n_fail;

    morse_symbol_framer #(
        .UNIT_CYCLES(60),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .morse     (morse),
        .code_ready(code_ready),
        .code_valid(code_valid),
        .code_bits (code_bits),
        .code_len  (code_len),
        .word_end  (word_end),
        .too_long  (too_long),
        .overrun   (overrun)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(negedge clock) begin
        if (!reset && code_valid && code_ready) begin
            recs.push_back({too_long, word_end, code_len, code_bits});
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic lvl, input int cycles);
        morse = lvl;
        repeat (cycles) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        morse      = 1'b0;
        code_ready = 1'b1;
        reset      = 1'b1;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
        drive(1'b0, 2);
    endtask

    task automatic add_vec(input int n, input int m0, input int m1, input int m2,
                           input int m3, input int m4, input int m5,
                           input int gap, input int tail, input logic [4:0] b,
                           input logic [2:0] l, input logic tl, input int nrec);
        vec_t v;
        v.n        = n;
        v.marks[0] = 12'(m0);
        v.marks[1] = 12'(m1);
        v.marks[2] = 12'(m2);
        v.marks[3] = 12'(m3);
        v.marks[4] = 12'(m4);
        v.marks[5] = 12'(m5);
        v.gap      = gap;
        v.tail     = tail;
        v.bits     = b;
        v.len      = l;
        v.tl       = tl;
        v.nrec     = nrec;
        vecs.push_back(v);
    endtask

    task automatic check_rec(input string name, input int idx, input logic [4:0] b,
                             input logic [2:0] l, input logic we, input logic tl);
        rec_t r;
        if (idx >= recs.size()) begin
            check({name, "_present"}, 0, 1);
        end else begin
            r = recs[idx];
            check({name, "_bits"}, int'(r.bits), int'(b));
            check({name, "_len"}, int'(r.len), int'(l));
            check({name, "_word_end"}, int'(r.we), int'(we));
            check({name, "_too_long"}, int'(r.tl), int'(tl));
        end
    endtask

    initial begin
        int base;
        n_checks   = 0;
        n_fail     = 0;
        morse      = 1'b0;
        code_ready = 1'b1;
        reset      = 1'b1;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        check("rst_valid", int'(code_valid), 0);
        check("rst_bits", int'(code_bits), 0);
        check("rst_len", int'(code_len), 0);
        check("rst_word_end", int'(word_end), 0);
        check("rst_too_long", int'(too_long), 0);
        check("rst_overrun", int'(overrun), 0);
        reset = 1'b0;

        //      n  m0   m1   m2   m3   m4   m5   gap tail  bits      len   tl  nrec
        add_vec(2, 60,  180, 0,   0,   0,   0,   60, 500, 5'b00010, 3'd2, 0,  2); // A + word
        add_vec(1, 60,  0,   0,   0,   0,   0,   60, 200, 5'b00000, 3'd1, 0,  1); // E
        add_vec(6, 180, 180, 180, 180, 180, 180, 60, 200, 5'b11111, 3'd5, 1,  1); // overlong
        add_vec(1, 119, 0,   0,   0,   0,   0,   60, 200, 5'b00000, 3'd1, 0,  1); // dot edge
        add_vec(1, 120, 0,   0,   0,   0,   0,   60, 200, 5'b00001, 3'd1, 0,  1); // dash edge
        add_vec(3, 180, 60,  180, 0,   0,   0,   60, 200, 5'b00101, 3'd3, 0,  1); // K
        add_vec(5, 60,  60,  60,  60,  180, 0,   60, 200, 5'b10000, 3'd5, 0,  1); // digit 4
        add_vec(1, 180, 0,   0,   0,   0,   0,   60, 450, 5'b00001, 3'd1, 0,  2); // T + word

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            do_reset();
            base = recs.size();
            for (int m = 0; m < vecs[i].n; m++) begin
                drive(1'b1, int'(vecs[i].marks[m]));
                if (m < vecs[i].n - 1) drive(1'b0, vecs[i].gap);
            end
            drive(1'b0, vecs[i].tail + 30);
            check({tag, "_count"}, recs.size() - base, vecs[i].nrec);
            check_rec(tag, base, vecs[i].bits, vecs[i].len, 1'b0, vecs[i].tl);
            if (vecs[i].nrec == 2) check_rec({tag, "_we"}, base + 1, 5'd0, 3'd0, 1'b1, 1'b0);
            check({tag, "_overrun"}, int'(overrun), 0);
        end

        // Short glitch before a clean E must not add an element.
        do_reset();
        base = recs.size();
        drive(1'b1, 3);
        drive(1'b0, 20);
        drive(1'b1, 60);
        drive(1'b0, 230);
        check("glitch_count", recs.size() - base, 1);
        check_rec("glitch", base, 5'b00000, 3'd1, 1'b0, 1'b0);

        // Overrun: E held in the slot, T arrives and is lost.
        do_reset();
        code_ready = 1'b0;
        base = recs.size();
        drive(1'b1, 60);
        drive(1'b0, 200);
        check("ovr_e_valid", int'(code_valid), 1);
        check("ovr_pre_flag", int'(overrun), 0);
        drive(1'b1, 180);
        drive(1'b0, 200);
        check("ovr_hold_valid", int'(code_valid), 1);
        check("ovr_hold_bits", int'(code_bits), 0);
        check("ovr_hold_len", int'(code_len), 1);
        check("ovr_flag", int'(overrun), 1);
        code_ready = 1'b1;
        drive(1'b0, 260);
        check("ovr_count", recs.size() - base, 2);
        check_rec("ovr_first", base, 5'b00000, 3'd1, 1'b0, 1'b0);
        check_rec("ovr_second", base + 1, 5'd0, 3'd0, 1'b1, 1'b0);
        check("ovr_sticky", int'(overrun), 1);

        // Reset pulse mid-mark clears a held record at once and drops the letter.
        do_reset();
        code_ready = 1'b0;
        drive(1'b1, 60);
        drive(1'b0, 200);
        check("mid_pre_valid", int'(code_valid), 1);
        drive(1'b1, 90);
        reset = 1'b1;
        morse = 1'b0;
        #1;
        check("mid_rst_valid", int'(code_valid), 0);
        check("mid_rst_len", int'(code_len), 0);
        check("mid_rst_overrun", int'(overrun), 0);
        @(posedge clock);
        #1;
        reset      = 1'b0;
        code_ready = 1'b1;
        base = recs.size();
        drive(1'b0, 250);
        check("mid_no_record", recs.size() - base, 0);
        drive(1'b1, 60);
        drive(1'b0, 230);
        check("mid_after_count", recs.size() - base, 1);
        check_rec("mid_after", base, 5'b00000, 3'd1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
